main_mem_responder: RTL and testbench
=====================================

// Module: main_mem_responder
// PURPOSE
//  Memory-side end of the cache-to-main-memory request interface: single-beat responder with backing store.
//  Accepts one-cycle mem_req_valid pulses (addr, rw, write data) and services them after a fixed latency.
//  Signals completion with a one-cycle mem_req_ready, carrying read data in that same cycle.
//  Sits between the cache controller and the system as main memory; also serves as the bench memory.
// PARAMETERS
//  ADDR_W    4      request address width; store depth = 2**ADDR_W bytes
//  DATA_W    8      data width
//  LATENCY   2      cycles from accepted valid to ready; legal range 1..15
//  INIT_XOR  8'h00  reset content: mem[i] = i[DATA_W-1:0] ^ INIT_XOR
// PORTS
//  clk              in   1       clock, rising edge
//  rst_n            in   1       synchronous, active-low reset
//  mem_req_addr     in   ADDR_W  request address
//  mem_req_dataout  in   DATA_W  write data from cache (rw=1)
//  mem_req_rw       in   1       1=write, 0=read
//  mem_req_valid    in   1       request strobe, one-cycle pulse
//  mem_req_ready    out  1       completion strobe, one cycle
//  mem_req_datain   out  DATA_W  read data to cache, valid while ready=1
//  busy             out  1       request in flight
//  req_count        out  8       accepted requests, wraps 255->0
//  overrun          out  1       sticky: valid seen while not IDLE
//  dbg_addr         in   ADDR_W  backdoor read address
//  dbg_data         out  DATA_W  mem[dbg_addr], combinational, no side effects
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE; ready=0; datain=0; busy=0; req_count=0; overrun=0;
//   lat_cnt=0; mem[i]=i^INIT_XOR for all i. Reset mid-transaction drops the transaction: no write commit, no ready.
//  FSM states IDLE, WAIT, RESPOND; all outputs registered except dbg_data.
//  IDLE: valid=1 at edge -> latch addr/rw/wdata; lat_cnt=LATENCY-1; req_count+1; busy=1.
//   Next state is WAIT, or RESPOND when LATENCY=1.
//  WAIT: lat_cnt decrements each cycle; at lat_cnt==1 -> RESPOND.
//  Timing: valid high in cycle t => ready high in cycle t+LATENCY, exactly one cycle.
//  RESPOND: ready=1.
//   Read: datain=mem[latched addr], loaded on entry.
//   Write: mem[latched addr]=latched wdata, committed at the edge ending RESPOND; datain unchanged.
//   Next state is IDLE unconditionally; busy=0 from the next cycle.
//  Back-to-back: ready in cycle r, new valid in cycle r+1 -> accepted (IDLE in r+1). No bubble required.
//  Valid while in WAIT or RESPOND: ignored, not counted; overrun=1 until reset.
//  datain holds its last read value outside RESPOND. Write-then-read of the same address returns the new data.
//  Cache requirement: the cache must sample ready only while its own valid is low. LATENCY>=1 guarantees this.
//  dbg_data reflects writes from the cycle after commit.
// STRUCTURE
//  Shared package mem_if_pkg:
//   MEM_ADDR_W=4, MEM_DATA_W=8; state encoding IDLE=2'b00, WAIT=2'b01, RESPOND=2'b10.
//   Reused by the cache controller and the bench.
//  One sub-module: main_mem_array.
//   Synchronous write port, registered read port, combinational debug port, reset-time init pattern.
//  FSM, latency counter and statistics stay in main_mem_responder.
// TESTING
//  1 Reset, then read addr 4'h5, LATENCY=2, INIT_XOR=0: valid at t -> ready at t+2 only, datain=8'h05; req_count=1.
//  2 Write 8'hA7 to 4'h3, then read 4'h3 issued the cycle after ready -> second ready returns 8'hA7; dbg_data(3)=8'hA7.
//  3 Cache write-back sequence: write 4'hC=8'h11, then read 4'h0 immediately -> two readies 2 cycles after each valid;
//    mem[C]=8'h11, datain=8'h00.
//  4 Second valid during WAIT -> ignored, overrun=1, req_count increments once, single ready.
//  5 rst_n low in WAIT of a write to 4'h2 of 8'hFF -> no ready; mem[2]=8'h02; all outputs at reset values.
//  6 LATENCY=1 build: valid at t -> ready at t+1; 256 requests -> req_count wraps to 0.

Source files
------------

// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache <-> main memory request interface.
// Used by the responder, the cache controller and the bench.
package mem_if_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 8;

    localparam int LAT_CNT_W  = 4;
    localparam int REQ_CNT_W  = 8;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_WAIT    = 2'b01;
    localparam logic [1:0] ST_RESPOND = 2'b10;

    // Counter value loaded at accept; the responder leaves WAIT when it reads 1.
    function automatic logic [LAT_CNT_W-1:0] lat_load(input int unsigned latency);
        return LAT_CNT_W'(latency - 1);
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Backing store: synchronous write, registered read, combinational debug read.
// Reset rewrites every word with its own index XORed with INIT_XOR.
module main_mem_array
    import mem_if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = MEM_ADDR_W,
    parameter int unsigned       DATA_W   = MEM_DATA_W,
    parameter logic [DATA_W-1:0] INIT_XOR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(i) ^ INIT_XOR;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register doubles as the responder's datain; holds between reads.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata    = r_rdata;
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/main_mem_responder.sv
// Memory-side responder: accepts single-cycle requests, answers after LATENCY cycles
// with a one-cycle ready strobe; reads return data in the ready cycle.
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = MEM_ADDR_W,
    parameter int unsigned       DATA_W   = MEM_DATA_W,
    parameter int unsigned       LATENCY  = 2,
    parameter logic [DATA_W-1:0] INIT_XOR = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    mem_req_addr,
    input  logic [DATA_W-1:0]    mem_req_dataout,
    input  logic                 mem_req_rw,
    input  logic                 mem_req_valid,
    output logic                 mem_req_ready,
    output logic [DATA_W-1:0]    mem_req_datain,
    output logic                 busy,
    output logic [REQ_CNT_W-1:0] req_count,
    output logic                 overrun,
    input  logic [ADDR_W-1:0]    dbg_addr,
    output logic [DATA_W-1:0]    dbg_data
);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [ADDR_W-1:0]    r_addr;
    logic                 r_rw;
    logic [DATA_W-1:0]    r_wdata;
    logic [LAT_CNT_W-1:0] r_lat_cnt;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_overrun;
    logic [REQ_CNT_W-1:0] r_req_count;

    logic                 w_accept;
    logic                 w_enter_respond;
    logic [ADDR_W-1:0]    w_cur_addr;
    logic                 w_cur_rw;
    logic                 w_rd_en;
    logic                 w_wr_en;

    assign w_accept = (r_state == ST_IDLE) && mem_req_valid;

    // With LATENCY=1 RESPOND is entered at the accept edge, before the request is latched.
    assign w_cur_addr = (r_state == ST_IDLE) ? mem_req_addr : r_addr;
    assign w_cur_rw   = (r_state == ST_IDLE) ? mem_req_rw   : r_rw;

    always_comb begin
        w_state_next    = r_state;
        w_enter_respond = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (mem_req_valid) begin
                    if (LATENCY == 1) begin
                        w_state_next    = ST_RESPOND;
                        w_enter_respond = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_lat_cnt == LAT_CNT_W'(1)) begin
                    w_state_next    = ST_RESPOND;
                    w_enter_respond = 1'b1;
                end
            end
            ST_RESPOND: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_rd_en = w_enter_respond && !w_cur_rw;
    assign w_wr_en = (r_state == ST_RESPOND) && r_rw;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_rw    <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_addr  <= mem_req_addr;
            r_rw    <= mem_req_rw;
            r_wdata <= mem_req_dataout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lat_cnt <= '0;
        end else if (w_accept) begin
            r_lat_cnt <= lat_load(LATENCY);
        end else if (r_state == ST_WAIT) begin
            r_lat_cnt <= r_lat_cnt - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= w_enter_respond;
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_state == ST_RESPOND) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Requests arriving outside IDLE are dropped and flagged until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_count <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_req_count <= r_req_count + REQ_CNT_W'(1);
            end
            if (mem_req_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    main_mem_array #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .INIT_XOR (INIT_XOR)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_wr_en),
        .i_waddr    (r_addr),
        .i_wdata    (r_wdata),
        .i_re       (w_rd_en),
        .i_raddr    (w_cur_addr),
        .o_rdata    (mem_req_datain),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    assign mem_req_ready = r_ready;
    assign busy          = r_busy;
    assign req_count     = r_req_count;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_main_mem_responder.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge monitor pops and compares.
// A second LATENCY=1 instance covers single-cycle latency and request-counter wrap.
module tb_main_mem_responder;
    import mem_if_pkg::*;

    localparam int          AW   = MEM_ADDR_W;
    localparam int          DW   = MEM_DATA_W;
    localparam int          LAT  = 2;
    localparam logic [7:0]  XOR1 = 8'h5A;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] addr, dbg_addr;
    logic [DW-1:0] dataout, datain, dbg_data;
    logic          rw, valid, ready, busy, overrun;
    logic [7:0]    req_count;

    logic [AW-1:0] a1, dbg_a1;
    logic [DW-1:0] do1, di1, dbg_d1;
    logic          rw1, v1, rdy1, busy1, ovr1;
    logic [7:0]    cnt1;

    always #5 clk = ~clk;

    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT), .INIT_XOR(8'h00)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req_addr(addr), .mem_req_dataout(dataout),
        .mem_req_rw(rw), .mem_req_valid(valid), .mem_req_ready(ready),
        .mem_req_datain(datain), .busy(busy), .req_count(req_count), .overrun(overrun),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    main_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .INIT_XOR(XOR1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_req_addr(a1), .mem_req_dataout(do1),
        .mem_req_rw(rw1), .mem_req_valid(v1), .mem_req_ready(rdy1),
        .mem_req_datain(di1), .busy(busy1), .req_count(cnt1), .overrun(ovr1),
        .dbg_addr(dbg_a1), .dbg_data(dbg_d1)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory image, last read value, stats, and response schedule.
    typedef struct { int due; logic [7:0] data; } exp_t;
    exp_t       q[$];
    logic [7:0] mdl_mem [16];
    logic [7:0] mdl_last;
    int         mdl_cnt;
    logic       mdl_ovr;
    int         acc_cyc;
    int         busy_until;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mdl_mem[i] = 8'(i) ^ 8'h00;
        mdl_last   = 8'h00;
        mdl_cnt    = 0;
        mdl_ovr    = 1'b0;
        acc_cyc    = -10;
        busy_until = -1;
        q.delete();
    endtask

    // Called just after a rising edge; drives valid for exactly one cycle.
    task automatic issue(input logic [3:0] a, input logic w, input logic [7:0] d);
        exp_t e;
        addr = a; rw = w; dataout = d; valid = 1'b1;
        if (cyc > busy_until) begin
            acc_cyc    = cyc;
            busy_until = cyc + LAT;
            mdl_cnt    = (mdl_cnt + 1) % 256;
            if (w) mdl_mem[a] = d;
            else   mdl_last   = mdl_mem[a];
            e.due  = cyc + LAT;
            e.data = mdl_last;
            q.push_back(e);
        end else begin
            mdl_ovr = 1'b1;
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic issue_idle(input logic [3:0] a, input logic w, input logic [7:0] d,
                              input int gap);
        while (cyc <= busy_until + gap) begin @(posedge clk); #1; end
        issue(a, w, d);
    endtask

    task automatic wait_idle();
        while (cyc <= busy_until) begin @(posedge clk); #1; end
    endtask

    task automatic check_dbg(input logic [3:0] a);
        wait_idle();
        dbg_addr = a;
        #1;
        chk("dbg_data", 32'(dbg_data), 32'(mdl_mem[a]));
    endtask

    task automatic check_stats(input string tag);
        wait_idle();
        chk({tag, "_req_count"}, 32'(req_count), 32'(mdl_cnt));
        chk({tag, "_overrun"}, 32'(overrun), 32'(mdl_ovr));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'(0));
        chk({tag, "_datain"}, 32'(datain), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_req_count"}, 32'(req_count), 32'(0));
        chk({tag, "_overrun"}, 32'(overrun), 32'(0));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", 32'(busy), 32'((cyc > acc_cyc) && (cyc <= busy_until)));
            if (ready) begin
                if (q.size() == 0) begin
                    chk("spurious_ready", 32'(ready), 32'(0));
                end else begin
                    e = q.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(e.due));
                    chk("datain", 32'(datain), 32'(e.data));
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                chk("missing_ready", 32'(ready), 32'(1));
                e = q.pop_front();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_seen;
        rst_n = 1'b0; valid = 1'b0; addr = '0; rw = 1'b0; dataout = '0; dbg_addr = '0;
        v1 = 1'b0; a1 = '0; rw1 = 1'b0; do1 = '0; dbg_a1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs("reset");
        mon_en = 1'b1;

        // Read after reset returns the init pattern.
        issue_idle(4'h5, 1'b0, 8'h00, 0);
        wait_idle();
        chk("t1_datain", 32'(datain), 32'(8'h05));
        chk("t1_req_count", 32'(req_count), 32'(1));

        // Write then back-to-back read of the same address.
        issue_idle(4'h3, 1'b1, 8'hA7, 0);
        issue_idle(4'h3, 1'b0, 8'h00, 0);
        wait_idle();
        chk("t2_datain", 32'(datain), 32'(8'hA7));
        check_dbg(4'h3);

        // Write-back followed immediately by a fill read.
        issue_idle(4'hC, 1'b1, 8'h11, 0);
        issue_idle(4'h0, 1'b0, 8'h00, 0);
        wait_idle();
        chk("t3_datain", 32'(datain), 32'(8'h00));
        check_dbg(4'hC);
        check_stats("t3");

        // Valid during WAIT is dropped and flagged.
        issue_idle(4'h7, 1'b0, 8'h00, 0);
        issue(4'h9, 1'b0, 8'h00);
        check_stats("t4");
        chk("t4_overrun", 32'(overrun), 32'(1));

        // Reset in the middle of a write: no commit, no ready.
        issue_idle(4'h2, 1'b1, 8'hFF, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1'b1;
        check_reset_outputs("t5");
        repeat (4) @(posedge clk);
        #1;
        check_dbg(4'h2);
        chk("t5_mem2", 32'(dbg_data), 32'(8'h02));

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            issue_idle(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                       8'($urandom), $urandom_range(0, 2));
            if (i % 8 == 7) check_dbg(4'($urandom_range(0, 15)));
        end
        check_stats("rand");

        // LATENCY=1 instance: ready one cycle after valid, then counter wrap.
        @(posedge clk); #1;
        a1 = 4'h9; rw1 = 1'b0; v1 = 1'b1;
        @(negedge clk);
        chk("l1_ready_t", 32'(rdy1), 32'(0));
        @(posedge clk); #1;
        v1 = 1'b0;
        @(negedge clk);
        chk("l1_ready_t1", 32'(rdy1), 32'(1));
        chk("l1_datain", 32'(di1), 32'(8'h09 ^ XOR1));
        @(negedge clk);
        chk("l1_ready_t2", 32'(rdy1), 32'(0));
        @(posedge clk); #1;
        rdy_seen = 0;
        for (int i = 1; i < 256; i++) begin
            a1 = 4'(i); rw1 = 1'b1; do1 = 8'(i); v1 = 1'b1;
            @(posedge clk); #1;
            v1 = 1'b0;
            @(negedge clk);
            if (rdy1) rdy_seen++;
            @(posedge clk); #1;
        end
        chk("l1_ready_count", 32'(rdy_seen), 32'(255));
        chk("l1_req_wrap", 32'(cnt1), 32'(0));
        chk("l1_overrun", 32'(ovr1), 32'(0));
        dbg_a1 = 4'hF;
        #1;
        chk("l1_dbg_f", 32'(dbg_d1), 32'(8'hFF));
        dbg_a1 = 4'h0;
        #1;
        chk("l1_dbg_0", 32'(dbg_d1), 32'(8'hF0));

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 32'(q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
